// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and the LSU, one transaction at a time,
// with a per-transaction timeout abort. Define ARB_RR_EN for round-robin, else LSU has priority.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_if_req,
    input  logic [ADDR_W-1:0] i_if_addr,
    output logic              o_if_gnt,
    output logic              o_if_rvalid,
    output logic [DATA_W-1:0] o_if_rdata,
    input  logic              i_ls_req,
    input  logic [ADDR_W-1:0] i_ls_addr,
    input  logic              i_ls_wren,
    input  logic [DATA_W-1:0] i_ls_wdata,
    input  logic [3:0]        i_ls_bmask,
    output logic              o_ls_gnt,
    output logic              o_ls_rvalid,
    output logic [DATA_W-1:0] o_ls_rdata,
    output logic              o_err,
    output logic              o_mem_req,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic              o_mem_wren,
    output logic [DATA_W-1:0] o_mem_wdata,
    output logic [3:0]        o_mem_bmask,
    input  logic              i_mem_ack,
    input  logic [DATA_W-1:0] i_mem_rdata
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic {StIdle, StBusy} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic               owner_ls_q;
    logic               last_ls_q;
    logic [ADDR_W-1:0]  mem_addr_q;
    logic               mem_wren_q;
    logic [DATA_W-1:0]  mem_wdata_q;
    logic [3:0]         mem_bmask_q;
    logic               if_rvalid_q, ls_rvalid_q, err_q;
    logic [DATA_W-1:0]  if_rdata_q, ls_rdata_q;

    logic               idle, busy, ls_pick, grant_if, grant_ls, timeout, done;
    logic [DATA_W-1:0]  resp_data;

    always_comb begin
        // Grants stay low while reset is held so every output reads 0 during reset.
        idle = (state_q == StIdle) && !i_reset;
        busy = (state_q == StBusy);
`ifdef ARB_RR_EN
        ls_pick = i_ls_req && (!i_if_req || !last_ls_q);
`else
        ls_pick = i_ls_req;
`endif
        grant_ls  = idle && ls_pick;
        grant_if  = idle && i_if_req && !ls_pick;
        timeout   = busy && !i_mem_ack && (cnt_q == CNT_LAST);
        done      = busy && (i_mem_ack || timeout);
        resp_data = (i_mem_ack && !mem_wren_q) ? i_mem_rdata : '0;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (grant_if || grant_ls) state_d = StBusy;
            StBusy:  if (done) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            owner_ls_q  <= 1'b0;
            last_ls_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_wren_q  <= 1'b0;
            mem_wdata_q <= '0;
            mem_bmask_q <= '0;
            if_rvalid_q <= 1'b0;
            ls_rvalid_q <= 1'b0;
            err_q       <= 1'b0;
            if_rdata_q  <= '0;
            ls_rdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            if_rvalid_q <= 1'b0;
            ls_rvalid_q <= 1'b0;
            err_q       <= 1'b0;
            if (grant_if || grant_ls) begin
                owner_ls_q  <= grant_ls;
                last_ls_q   <= grant_ls;
                cnt_q       <= '0;
                mem_addr_q  <= grant_ls ? i_ls_addr : i_if_addr;
                mem_wren_q  <= grant_ls && i_ls_wren;
                mem_wdata_q <= grant_ls ? i_ls_wdata : '0;
                mem_bmask_q <= grant_ls ? i_ls_bmask : 4'h0;
            end else if (busy && !done) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
            if (done) begin
                err_q <= !i_mem_ack;
                if (owner_ls_q) begin
                    ls_rvalid_q <= 1'b1;
                    ls_rdata_q  <= resp_data;
                end else begin
                    if_rvalid_q <= 1'b1;
                    if_rdata_q  <= resp_data;
                end
            end
        end
    end

    assign o_if_gnt    = grant_if;
    assign o_ls_gnt    = grant_ls;
    assign o_if_rvalid = if_rvalid_q;
    assign o_if_rdata  = if_rdata_q;
    assign o_ls_rvalid = ls_rvalid_q;
    assign o_ls_rdata  = ls_rdata_q;
    assign o_err       = err_q;
    assign o_mem_req   = busy;
    assign o_mem_addr  = mem_addr_q;
    assign o_mem_wren  = mem_wren_q;
    assign o_mem_wdata = mem_wdata_q;
    assign o_mem_bmask = mem_bmask_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with TIMEOUT_CYCLES = 4; expectations follow ARB_RR_EN.
module tb_mem_port_arbiter;

    logic        i_clk, i_reset;
    logic        i_if_req, i_ls_req, i_ls_wren, i_mem_ack;
    logic [31:0] i_if_addr, i_ls_addr, i_ls_wdata, i_mem_rdata;
    logic [3:0]  i_ls_bmask, o_mem_bmask;
    logic        o_if_gnt, o_if_rvalid, o_ls_gnt, o_ls_rvalid, o_err, o_mem_req, o_mem_wren;
    logic [31:0] o_if_rdata, o_ls_rdata, o_mem_addr, o_mem_wdata;

    int vectors = 0;
    int miscompares = 0;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(4)) dut (
        .i_clk(i_clk), .i_reset(i_reset),
        .i_if_req(i_if_req), .i_if_addr(i_if_addr), .o_if_gnt(o_if_gnt),
        .o_if_rvalid(o_if_rvalid), .o_if_rdata(o_if_rdata),
        .i_ls_req(i_ls_req), .i_ls_addr(i_ls_addr), .i_ls_wren(i_ls_wren),
        .i_ls_wdata(i_ls_wdata), .i_ls_bmask(i_ls_bmask), .o_ls_gnt(o_ls_gnt),
        .o_ls_rvalid(o_ls_rvalid), .o_ls_rdata(o_ls_rdata), .o_err(o_err),
        .o_mem_req(o_mem_req), .o_mem_addr(o_mem_addr), .o_mem_wren(o_mem_wren),
        .o_mem_wdata(o_mem_wdata), .o_mem_bmask(o_mem_bmask),
        .i_mem_ack(i_mem_ack), .i_mem_rdata(i_mem_rdata)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Start of a new cycle: inputs are applied just after the rising edge.
    task automatic cyc();
        @(posedge i_clk);
        #1;
    endtask

    function automatic logic [164:0] all_outs();
        return {o_if_gnt, o_ls_gnt, o_if_rvalid, o_ls_rvalid, o_err, o_mem_req, o_mem_wren,
                o_mem_bmask, o_mem_addr, o_mem_wdata, o_if_rdata, o_ls_rdata, 2'b00};
    endfunction

    task automatic test_reset();
        i_reset = 1'b1; i_if_req = 1'b1; i_ls_req = 1'b1; i_mem_ack = 1'b0;
        i_if_addr = 32'h100; i_ls_addr = 32'h200; i_ls_wren = 1'b0;
        i_ls_wdata = 32'h0; i_ls_bmask = 4'h0; i_mem_rdata = 32'h0;
        for (int k = 0; k < 3; k++) begin
            cyc(); #1;
            vectors++;
            if (all_outs() !== '0) begin
                miscompares++;
                $display("FAIL reset_outputs[%0d]: got %h want 0", k, all_outs());
            end
        end
    endtask

    task automatic test_back_to_back();
        logic exp_ls [4];
        for (int g = 0; g < 4; g++) begin
`ifdef ARB_RR_EN
            exp_ls[g] = (g % 2 == 0);
`else
            exp_ls[g] = 1'b1;
`endif
        end
        for (int k = 0; k < 8; k++) begin
            cyc();
            i_reset = 1'b0; i_if_req = 1'b1; i_ls_req = 1'b1; i_mem_ack = 1'b1;
            i_mem_rdata = 32'h1000 + k;
            #1;
            vectors++;
            if (k % 2 == 0) begin
                if ({o_ls_gnt, o_if_gnt} !== {exp_ls[k/2], !exp_ls[k/2]}) begin
                    miscompares++;
                    $display("FAIL b2b_gnt[%0d]: got ls/if %b%b want %b%b", k, o_ls_gnt, o_if_gnt,
                             exp_ls[k/2], !exp_ls[k/2]);
                end
            end else begin
                if ({o_ls_gnt, o_if_gnt, o_mem_req} !== 3'b001) begin
                    miscompares++;
                    $display("FAIL b2b_busy[%0d]: got gnt/req %b%b%b want 001", k, o_ls_gnt,
                             o_if_gnt, o_mem_req);
                end
            end
            if (k >= 2 && k % 2 == 0) begin
                vectors++;
                if ({o_ls_rvalid, o_if_rvalid, o_err} !==
                    {exp_ls[k/2-1], !exp_ls[k/2-1], 1'b0}) begin
                    miscompares++;
                    $display("FAIL b2b_rvalid[%0d]: got ls/if/err %b%b%b want %b%b0", k,
                             o_ls_rvalid, o_if_rvalid, o_err, exp_ls[k/2-1], !exp_ls[k/2-1]);
                end
            end
        end
        cyc(); i_ls_req = 1'b0; #1;
        vectors++;
        if ({o_if_gnt, o_ls_gnt} !== 2'b10) begin
            miscompares++;
            $display("FAIL b2b_if_after_ls_drop: got if/ls %b%b want 10", o_if_gnt, o_ls_gnt);
        end
        cyc(); i_if_req = 1'b0; #1;
        cyc(); i_mem_ack = 1'b0; #1;
        cyc(); #1;
    endtask

    task automatic test_fetch_read();
        cyc(); i_if_req = 1'b1; i_if_addr = 32'h0000_0010; #1;
        vectors++;
        if ({o_if_gnt, o_ls_gnt, o_mem_req} !== 3'b100) begin
            miscompares++;
            $display("FAIL fetch_gnt: got if/ls/req %b%b%b want 100", o_if_gnt, o_ls_gnt, o_mem_req);
        end
        cyc(); i_if_req = 1'b0; #1;
        vectors++;
        if ({o_mem_req, o_mem_addr, o_mem_wren, o_mem_bmask, o_if_rvalid} !==
            {1'b1, 32'h10, 1'b0, 4'h0, 1'b0}) begin
            miscompares++;
            $display("FAIL fetch_mem_drive: got req %b addr %h wren %b bmask %h", o_mem_req,
                     o_mem_addr, o_mem_wren, o_mem_bmask);
        end
        cyc(); i_mem_ack = 1'b1; i_mem_rdata = 32'h0000_0013; #1;
        vectors++;
        if (o_mem_req !== 1'b1) begin
            miscompares++;
            $display("FAIL fetch_req_c2: got %b want 1", o_mem_req);
        end
        cyc(); i_mem_ack = 1'b0; #1;
        vectors++;
        if ({o_if_rvalid, o_if_rdata, o_err, o_ls_rvalid, o_mem_req} !==
            {1'b1, 32'h13, 1'b0, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL fetch_resp: got rvalid %b rdata %h err %b ls_rvalid %b req %b",
                     o_if_rvalid, o_if_rdata, o_err, o_ls_rvalid, o_mem_req);
        end
        cyc(); #1;
        vectors++;
        if (o_if_rvalid !== 1'b0) begin
            miscompares++;
            $display("FAIL fetch_pulse: got %b want 0", o_if_rvalid);
        end
    endtask

    task automatic test_ls_store();
        cyc(); i_ls_req = 1'b1; i_ls_addr = 32'h0000_2000; i_ls_wren = 1'b1;
        i_ls_wdata = 32'hDEAD_BEEF; i_ls_bmask = 4'hF; #1;
        vectors++;
        if ({o_ls_gnt, o_if_gnt} !== 2'b10) begin
            miscompares++;
            $display("FAIL store_gnt: got ls/if %b%b want 10", o_ls_gnt, o_if_gnt);
        end
        cyc(); i_ls_req = 1'b0; i_mem_ack = 1'b1; i_mem_rdata = 32'h55AA_55AA; #1;
        vectors++;
        if ({o_mem_req, o_mem_wren, o_mem_addr, o_mem_wdata, o_mem_bmask} !==
            {1'b1, 1'b1, 32'h2000, 32'hDEAD_BEEF, 4'hF}) begin
            miscompares++;
            $display("FAIL store_mem_drive: got req %b wren %b addr %h wdata %h bmask %h",
                     o_mem_req, o_mem_wren, o_mem_addr, o_mem_wdata, o_mem_bmask);
        end
        cyc(); i_mem_ack = 1'b0; #1;
        vectors++;
        if ({o_ls_rvalid, o_ls_rdata, o_err, o_if_rvalid, o_if_rdata} !==
            {1'b1, 32'h0, 1'b0, 1'b0, 32'h13}) begin
            miscompares++;
            $display("FAIL store_resp: got rvalid %b rdata %h err %b if_rvalid %b if_rdata %h",
                     o_ls_rvalid, o_ls_rdata, o_err, o_if_rvalid, o_if_rdata);
        end
    endtask

    task automatic test_ls_load();
        cyc(); i_ls_req = 1'b1; i_ls_addr = 32'h0000_2004; i_ls_wren = 1'b0;
        i_ls_bmask = 4'h3; #1;
        cyc(); i_ls_req = 1'b0; i_mem_ack = 1'b1; i_mem_rdata = 32'hCAFE_F00D; #1;
        vectors++;
        if ({o_mem_wren, o_mem_addr, o_mem_bmask} !== {1'b0, 32'h2004, 4'h3}) begin
            miscompares++;
            $display("FAIL load_mem_drive: got wren %b addr %h bmask %h", o_mem_wren, o_mem_addr,
                     o_mem_bmask);
        end
        cyc(); i_mem_ack = 1'b0; #1;
        vectors++;
        if ({o_ls_rvalid, o_ls_rdata, o_err} !== {1'b1, 32'hCAFE_F00D, 1'b0}) begin
            miscompares++;
            $display("FAIL load_resp: got rvalid %b rdata %h err %b", o_ls_rvalid, o_ls_rdata, o_err);
        end
    endtask

    task automatic test_timeout();
        cyc(); i_if_req = 1'b1; i_if_addr = 32'h40; #1;
        vectors++;
        if (o_if_gnt !== 1'b1) begin
            miscompares++;
            $display("FAIL timeout_gnt: got %b want 1", o_if_gnt);
        end
        for (int k = 1; k <= 4; k++) begin
            cyc(); i_if_req = 1'b0; #1;
            vectors++;
            if ({o_mem_req, o_if_rvalid, o_err} !== 3'b100) begin
                miscompares++;
                $display("FAIL timeout_busy[%0d]: got req/rvalid/err %b%b%b want 100", k,
                         o_mem_req, o_if_rvalid, o_err);
            end
        end
        cyc(); i_ls_req = 1'b1; i_ls_addr = 32'h3000; i_ls_wren = 1'b0; #1;
        vectors++;
        if ({o_if_rvalid, o_err, o_if_rdata, o_mem_req, o_ls_gnt} !==
            {1'b1, 1'b1, 32'h0, 1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL timeout_abort: got rvalid %b err %b rdata %h req %b ls_gnt %b",
                     o_if_rvalid, o_err, o_if_rdata, o_mem_req, o_ls_gnt);
        end
        cyc(); i_ls_req = 1'b0; i_mem_ack = 1'b1; i_mem_rdata = 32'h77; #1;
        vectors++;
        if ({o_err, o_if_rvalid, o_mem_req} !== 3'b001) begin
            miscompares++;
            $display("FAIL timeout_err_pulse: got err/rvalid/req %b%b%b want 001", o_err,
                     o_if_rvalid, o_mem_req);
        end
        cyc(); i_mem_ack = 1'b0; #1;
        vectors++;
        if ({o_ls_rvalid, o_ls_rdata, o_err} !== {1'b1, 32'h77, 1'b0}) begin
            miscompares++;
            $display("FAIL timeout_next_load: got rvalid %b rdata %h err %b", o_ls_rvalid,
                     o_ls_rdata, o_err);
        end
    endtask

    task automatic test_ack_at_limit();
        cyc(); i_if_req = 1'b1; i_if_addr = 32'h44; #1;
        for (int k = 1; k <= 3; k++) begin
            cyc(); i_if_req = 1'b0; #1;
        end
        cyc(); i_mem_ack = 1'b1; i_mem_rdata = 32'hABCD_1234; #1;
        vectors++;
        if (o_mem_req !== 1'b1) begin
            miscompares++;
            $display("FAIL limit_req: got %b want 1", o_mem_req);
        end
        cyc(); i_mem_ack = 1'b0; #1;
        vectors++;
        if ({o_if_rvalid, o_err, o_if_rdata} !== {1'b1, 1'b0, 32'hABCD_1234}) begin
            miscompares++;
            $display("FAIL limit_resp: got rvalid %b err %b rdata %h", o_if_rvalid, o_err,
                     o_if_rdata);
        end
    endtask

    task automatic test_reset_mid();
        cyc(); i_ls_req = 1'b1; i_ls_addr = 32'h3000; i_ls_wren = 1'b0; #1;
        cyc(); i_ls_req = 1'b0; #1;
        vectors++;
        if (o_mem_req !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_busy: got %b want 1", o_mem_req);
        end
        for (int k = 0; k < 2; k++) begin
            cyc(); i_reset = 1'b1; i_ls_req = 1'b1; i_mem_ack = 1'b1; #1;
            vectors++;
            if (all_outs() !== '0) begin
                miscompares++;
                $display("FAIL mid_reset_outputs[%0d]: got %h want 0", k, all_outs());
            end
        end
        cyc(); i_reset = 1'b0; i_mem_ack = 1'b0; #1;
        vectors++;
        if ({o_ls_gnt, o_ls_rvalid, o_if_rvalid, o_mem_req} !== 4'b1000) begin
            miscompares++;
            $display("FAIL mid_first_gnt: got gnt/rvalid/if_rvalid/req %b%b%b%b want 1000",
                     o_ls_gnt, o_ls_rvalid, o_if_rvalid, o_mem_req);
        end
        cyc(); i_ls_req = 1'b0; i_mem_ack = 1'b1; i_mem_rdata = 32'h99; #1;
        vectors++;
        if ({o_ls_rvalid, o_mem_addr} !== {1'b0, 32'h3000}) begin
            miscompares++;
            $display("FAIL mid_no_stale_rvalid: got rvalid %b addr %h", o_ls_rvalid, o_mem_addr);
        end
        cyc(); i_mem_ack = 1'b0; #1;
        vectors++;
        if ({o_ls_rvalid, o_ls_rdata} !== {1'b1, 32'h99}) begin
            miscompares++;
            $display("FAIL mid_resp: got rvalid %b rdata %h", o_ls_rvalid, o_ls_rdata);
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_fetch_read();
        test_ls_store();
        test_ls_load();
        test_timeout();
        test_ack_at_limit();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
